// File: rtl/accel_axis_filter.sv
// ---------------------------------------------------------------------------
// accel_axis_filter
//
// Per-axis moving-average and hysteretic tilt detector for packed
// accelerometer samples. Each accepted sample is folded into a boxcar sum of
// the last 2^LOG2_DEPTH samples per axis, one axis per cycle. The averaged
// axes are then published with a one-cycle valid pulse.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   clear         synchronous flush of window, tilt and overrun state
//   sample_valid  one-cycle strobe qualifying sample_data
//   sample_data   packed samples, axis a in [a*DATA_W +: DATA_W]
//   busy          high while a sample is being folded in
//   avg_valid     one-cycle pulse when avg_data / tilt / fill_done update
//   avg_data      averaged axes, same packing as sample_data, held between updates
//   tilt          per-axis hysteretic tilt flag
//   fill_done     window has been filled since reset or clear
//   overrun       sticky flag: a sample arrived while busy and was dropped
// ---------------------------------------------------------------------------
module accel_axis_filter #(
  parameter int NUM_AXES    = 3,
  parameter int DATA_W      = 16,
  parameter int LOG2_DEPTH  = 3,
  parameter int TILT_THRESH = 200,
  parameter int TILT_HYST   = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         sample_valid,
  input  logic [NUM_AXES*DATA_W-1:0]   sample_data,
  output logic                         busy,
  output logic                         avg_valid,
  output logic [NUM_AXES*DATA_W-1:0]   avg_data,
  output logic [NUM_AXES-1:0]          tilt,
  output logic                         fill_done,
  output logic                         overrun
);

  localparam int DEPTH  = 1 << LOG2_DEPTH;
  localparam int SUM_W  = DATA_W + LOG2_DEPTH;
  localparam int AXIS_W = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
  localparam int FILL_W = LOG2_DEPTH + 1;

  localparam logic [FILL_W-1:0] FILL_FULL    = FILL_W'(DEPTH);
  localparam logic [AXIS_W-1:0] LAST_AXIS    = AXIS_W'(NUM_AXES - 1);
  localparam logic [DATA_W:0]   TILT_SET_LVL = (DATA_W + 1)'(TILT_THRESH);
  localparam logic [DATA_W:0]   TILT_CLR_LVL = (DATA_W + 1)'(TILT_THRESH - TILT_HYST);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } state_e;

  state_e                        state_q, state_d;
  logic [AXIS_W-1:0]             axis_q, axis_d;
  logic [NUM_AXES*DATA_W-1:0]    sampleLatch_q, sampleLatch_d;
  logic signed [SUM_W-1:0]       sum_q [NUM_AXES];
  logic signed [SUM_W-1:0]       sum_d [NUM_AXES];
  logic [LOG2_DEPTH-1:0]         wrPtr_q, wrPtr_d;
  logic [FILL_W-1:0]             fillCnt_q, fillCnt_d;
  logic                          fillDone_q, fillDone_d;
  logic [NUM_AXES-1:0]           tilt_q, tilt_d;
  logic                          avgValid_q, avgValid_d;
  logic [NUM_AXES*DATA_W-1:0]    avgData_q, avgData_d;
  logic                          overrun_q, overrun_d;

  // Ring buffer holding the window; never reset, only read once it is full.
  logic signed [DATA_W-1:0]      ringBuf [NUM_AXES][DEPTH];

  logic signed [DATA_W-1:0]      newSample;
  logic signed [DATA_W-1:0]      oldestSample;
  logic signed [SUM_W-1:0]       sumUpd;
  logic signed [SUM_W-1:0]       sumAfter [NUM_AXES];
  logic                          bufWe;
  logic                          lastAxis;
  logic [FILL_W-1:0]             fillCntInc;
  logic                          fillDoneNext;
  logic [NUM_AXES*DATA_W-1:0]    avgNext;
  logic [NUM_AXES-1:0]           tiltNext;

  // Datapath for the axis currently being folded in. Until the window is
  // full the slot being overwritten holds no real sample, so it counts as 0.
  always_comb begin
    newSample    = sampleLatch_q[axis_q*DATA_W +: DATA_W];
    oldestSample = fillDone_q ? ringBuf[axis_q][wrPtr_q] : '0;
    sumUpd       = sum_q[axis_q] + SUM_W'(newSample) - SUM_W'(oldestSample);
    lastAxis     = (axis_q == LAST_AXIS);
  end

  // Sums as they will stand after this cycle's axis update; the averages
  // published on the last ACC cycle must already include the final axis.
  always_comb begin
    sumAfter         = sum_q;
    sumAfter[axis_q] = sumUpd;
  end

  // Fill counter saturates at the window size; fill_done rises together with
  // the avg_valid of the sample that completes the window.
  always_comb begin
    fillCntInc   = (fillCnt_q == FILL_FULL) ? fillCnt_q : fillCnt_q + 1'b1;
    fillDoneNext = (fillCntInc == FILL_FULL);
  end

  // Per-axis average and tilt. The magnitude uses one extra bit so the most
  // negative average has an exact absolute value. Tilt stays 0 until the
  // window is full, then sets above the threshold and clears below
  // threshold minus hysteresis.
  for (genvar a = 0; a < NUM_AXES; a++) begin : gAxis
    logic signed [DATA_W-1:0] avgAxis;
    logic signed [DATA_W:0]   avgWide;
    logic        [DATA_W:0]   avgMag;

    assign avgAxis = DATA_W'(sumAfter[a] >>> LOG2_DEPTH);
    assign avgWide = {avgAxis[DATA_W-1], avgAxis};
    assign avgMag  = avgWide[DATA_W] ? -avgWide : avgWide;
    assign avgNext[a*DATA_W +: DATA_W] = avgAxis;

    always_comb begin
      tiltNext[a] = tilt_q[a];
      if (avgMag > TILT_SET_LVL) begin
        tiltNext[a] = 1'b1;
      end else if (avgMag < TILT_CLR_LVL) begin
        tiltNext[a] = 1'b0;
      end
      if (!fillDoneNext) begin
        tiltNext[a] = 1'b0;
      end
    end
  end

  // Control FSM next-state and register updates. The outputs are registered
  // on the transition into OUT so they appear in the OUT cycle itself.
  // clear overrides everything except avg_data, which keeps its last value.
  always_comb begin
    state_d       = state_q;
    axis_d        = axis_q;
    sampleLatch_d = sampleLatch_q;
    sum_d         = sum_q;
    wrPtr_d       = wrPtr_q;
    fillCnt_d     = fillCnt_q;
    fillDone_d    = fillDone_q;
    tilt_d        = tilt_q;
    avgValid_d    = 1'b0;
    avgData_d     = avgData_q;
    overrun_d     = overrun_q;
    bufWe         = 1'b0;

    case (state_q)
      IDLE: begin
        if (sample_valid) begin
          sampleLatch_d = sample_data;
          axis_d        = '0;
          state_d       = ACC;
        end
      end
      ACC: begin
        bufWe = 1'b1;
        sum_d = sumAfter;
        if (lastAxis) begin
          state_d    = OUT;
          avgValid_d = 1'b1;
          avgData_d  = avgNext;
          tilt_d     = tiltNext;
          wrPtr_d    = wrPtr_q + 1'b1;
          fillCnt_d  = fillCntInc;
          fillDone_d = fillDoneNext;
        end else begin
          axis_d = axis_q + 1'b1;
        end
      end
      OUT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (sample_valid && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    if (clear) begin
      state_d    = IDLE;
      axis_d     = '0;
      wrPtr_d    = '0;
      fillCnt_d  = '0;
      fillDone_d = 1'b0;
      tilt_d     = '0;
      avgValid_d = 1'b0;
      avgData_d  = avgData_q;
      overrun_d  = 1'b0;
      bufWe      = 1'b0;
      for (int a = 0; a < NUM_AXES; a++) begin
        sum_d[a] = '0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      axis_q        <= '0;
      sampleLatch_q <= '0;
      for (int a = 0; a < NUM_AXES; a++) begin
        sum_q[a] <= '0;
      end
      wrPtr_q       <= '0;
      fillCnt_q     <= '0;
      fillDone_q    <= 1'b0;
      tilt_q        <= '0;
      avgValid_q    <= 1'b0;
      avgData_q     <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      axis_q        <= axis_d;
      sampleLatch_q <= sampleLatch_d;
      sum_q         <= sum_d;
      wrPtr_q       <= wrPtr_d;
      fillCnt_q     <= fillCnt_d;
      fillDone_q    <= fillDone_d;
      tilt_q        <= tilt_d;
      avgValid_q    <= avgValid_d;
      avgData_q     <= avgData_d;
      overrun_q     <= overrun_d;
    end
  end

  // Window storage; written with the new sample as its axis is folded in.
  always_ff @(posedge clk) begin
    if (bufWe) begin
      ringBuf[axis_q][wrPtr_q] <= newSample;
    end
  end

  assign busy      = (state_q != IDLE);
  assign avg_valid = avgValid_q;
  assign avg_data  = avgData_q;
  assign tilt      = tilt_q;
  assign fill_done = fillDone_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_accel_axis_filter.sv
// ---------------------------------------------------------------------------
// tb_accel_axis_filter
//
// Directed bench for accel_axis_filter with default parameters (3 axes,
// 16-bit data, window of 8, threshold 200, hysteresis 32). Sample streams are
// kept in a table of {inputs, expected outputs}; overrun, clear and reset
// corner cases are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_accel_axis_filter;

  localparam int NA = 3;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              clear;
  logic              sample_valid;
  logic [NA*DW-1:0]  sample_data;
  logic              busy;
  logic              avg_valid;
  logic [NA*DW-1:0]  avg_data;
  logic [NA-1:0]     tilt;
  logic              fill_done;
  logic              overrun;

  accel_axis_filter #(
    .NUM_AXES    (NA),
    .DATA_W      (DW),
    .LOG2_DEPTH  (3),
    .TILT_THRESH (200),
    .TILT_HYST   (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .busy         (busy),
    .avg_valid    (avg_valid),
    .avg_data     (avg_data),
    .tilt         (tilt),
    .fill_done    (fill_done),
    .overrun      (overrun)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  typedef struct {
    int        d0, d1, d2;
    bit        chk;
    int        e0, e1, e2;
    logic [2:0] eTilt;
    logic      eFill;
  } vec_t;

  vec_t       vecs[$];
  int         testsRun    = 0;
  int         testsFailed = 0;
  int         capA0, capA1, capA2;
  logic [2:0] capTilt;
  logic       capFill;
  int         capPulses;

  // Single comparison; every check in the bench goes through here.
  task automatic checkOutput(input string name, input longint act, input longint exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int axisVal(input int a);
    logic signed [DW-1:0] t;
    t = avg_data[a*DW +: DW];
    return int'(t);
  endfunction

  task automatic addRow(input int d0, d1, d2, input bit chk, input int e0, e1, e2,
                        input logic [2:0] eTilt, input logic eFill);
    vec_t v;
    v.d0 = d0; v.d1 = d1; v.d2 = d2; v.chk = chk;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.eTilt = eTilt; v.eFill = eFill;
    vecs.push_back(v);
  endtask

  // Drive one sample and watch the following 9 cycles; lat is the number of
  // cycles from the strobe to the first avg_valid (-1 if none arrived).
  task automatic applyStimulus(input int d0, d1, d2, output int lat);
    lat       = -1;
    capPulses = 0;
    @(negedge clk);
    sample_data  = {DW'(d2), DW'(d1), DW'(d0)};
    sample_valid = 1'b1;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      sample_valid = 1'b0;
      if (avg_valid) begin
        capPulses++;
        if (lat < 0) begin
          lat     = i;
          capA0   = axisVal(0);
          capA1   = axisVal(1);
          capA2   = axisVal(2);
          capTilt = tilt;
          capFill = fill_done;
        end
      end
    end
  endtask

  task automatic runRows(input int lo, input int hi);
    int lat;
    for (int i = lo; i < hi; i++) begin
      applyStimulus(vecs[i].d0, vecs[i].d1, vecs[i].d2, lat);
      checkOutput($sformatf("row%0d_latency", i), lat, 4);
      if (vecs[i].chk) begin
        checkOutput($sformatf("row%0d_avg0", i), capA0, vecs[i].e0);
        checkOutput($sformatf("row%0d_avg1", i), capA1, vecs[i].e1);
        checkOutput($sformatf("row%0d_avg2", i), capA2, vecs[i].e2);
        checkOutput($sformatf("row%0d_tilt", i), capTilt, vecs[i].eTilt);
        checkOutput($sformatf("row%0d_fill", i), capFill, vecs[i].eFill);
      end
    end
  endtask

  task automatic pulseClear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    int idleBad;
    int pulses;
    int lat;

    reset        = 1'b1;
    clear        = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_avg_valid", avg_valid, 0);
    checkOutput("rst_avg_data", avg_data, 0);
    checkOutput("rst_tilt", tilt, 0);
    checkOutput("rst_fill_done", fill_done, 0);
    checkOutput("rst_overrun", overrun, 0);
    reset = 1'b0;

    // Quiet idle after reset.
    idleBad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || avg_valid || (avg_data != '0) || (tilt != '0) || fill_done || overrun) begin
        idleBad++;
      end
    end
    checkOutput("idle_quiet_cycles_bad", idleBad, 0);

    // Rows 0-7: fill with (800,-800,0); average ramps by 100 per sample.
    for (int k = 1; k <= 8; k++) begin
      addRow(800, -800, 0, 1'b1, 100 * k, -100 * k, 0,
             (k == 8) ? 3'b011 : 3'b000, (k == 8));
    end
    // Rows 8-15: (170,-170,0); stays inside the hysteresis band.
    addRow(170, -170, 0, 1'b1, 721, -722, 0, 3'b011, 1'b1);
    for (int k = 2; k <= 7; k++) addRow(170, -170, 0, 1'b0, 0, 0, 0, 3'b000, 1'b0);
    addRow(170, -170, 0, 1'b1, 170, -170, 0, 3'b011, 1'b1);
    // Rows 16-23: (160,0,0); axis 1 clears first, axis 0 one sample later.
    addRow(160, 0, 0, 1'b1, 168, -149, 0, 3'b001, 1'b1);
    addRow(160, 0, 0, 1'b1, 167, -128, 0, 3'b000, 1'b1);
    for (int k = 3; k <= 7; k++) addRow(160, 0, 0, 1'b0, 0, 0, 0, 3'b000, 1'b0);
    addRow(160, 0, 0, 1'b1, 160, 0, 0, 3'b000, 1'b1);
    // Rows 24-31: (201,0,0); sets tilt only once the average exceeds 200.
    for (int k = 1; k <= 6; k++) addRow(201, 0, 0, 1'b0, 0, 0, 0, 3'b000, 1'b0);
    addRow(201, 0, 0, 1'b1, 195, 0, 0, 3'b000, 1'b1);
    addRow(201, 0, 0, 1'b1, 201, 0, 0, 3'b001, 1'b1);
    // Rows 32-47: extremes, after a clear.
    addRow(-32768, -32768, -32768, 1'b1, -4096, -4096, -4096, 3'b000, 1'b0);
    for (int k = 2; k <= 7; k++) addRow(-32768, -32768, -32768, 1'b0, 0, 0, 0, 3'b000, 1'b0);
    addRow(-32768, -32768, -32768, 1'b1, -32768, -32768, -32768, 3'b111, 1'b1);
    addRow(32767, 32767, 32767, 1'b1, -24577, -24577, -24577, 3'b111, 1'b1);
    for (int k = 2; k <= 7; k++) addRow(32767, 32767, 32767, 1'b0, 0, 0, 0, 3'b000, 1'b0);
    addRow(32767, 32767, 32767, 1'b1, 32767, 32767, 32767, 3'b111, 1'b1);

    runRows(0, 32);

    // Overrun: second strobe two cycles after the first is dropped.
    @(negedge clk);
    sample_data  = {16'sd0, 16'sd0, 16'sd1001};
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    checkOutput("ovr_busy_t1", busy, 1);
    pulses = (avg_valid) ? 1 : 0;
    @(negedge clk);
    checkOutput("ovr_flag_t2", overrun, 0);
    sample_data  = {16'sd5000, 16'sd5000, 16'sd5000};
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    checkOutput("ovr_flag_t3", overrun, 1);
    for (int i = 0; i < 12; i++) begin
      if (avg_valid) begin
        pulses++;
        capA0 = axisVal(0);
        capA1 = axisVal(1);
        capTilt = tilt;
      end
      @(negedge clk);
    end
    checkOutput("ovr_pulses", pulses, 1);
    checkOutput("ovr_avg0", capA0, 301);
    checkOutput("ovr_avg1", capA1, 0);
    checkOutput("ovr_tilt", capTilt, 3'b001);
    checkOutput("ovr_sticky", overrun, 1);
    pulseClear();
    checkOutput("clr_overrun", overrun, 0);
    checkOutput("clr_fill_done", fill_done, 0);
    checkOutput("clr_tilt", tilt, 0);
    checkOutput("clr_avg_held", axisVal(0), 301);

    runRows(32, 48);

    // clear during the second cycle of processing aborts the sample.
    @(negedge clk);
    sample_data  = {16'sd1234, 16'sd1234, 16'sd1234};
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    pulses = (avg_valid) ? 1 : 0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (avg_valid) pulses++;
      @(negedge clk);
    end
    checkOutput("abort_pulses", pulses, 0);
    checkOutput("abort_fill_done", fill_done, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_avg_held", axisVal(2), 32767);
    applyStimulus(800, 800, 800, lat);
    checkOutput("post_abort_latency", lat, 4);
    checkOutput("post_abort_avg0", capA0, 100);
    checkOutput("post_abort_avg2", capA2, 100);
    checkOutput("post_abort_fill", capFill, 0);

    // Asynchronous reset in the middle of processing.
    @(negedge clk);
    sample_data  = {16'sd50, 16'sd50, 16'sd50};
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_avg_data", avg_data, 0);
    checkOutput("midrst_avg_valid", avg_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("midrst_no_pulse", avg_valid, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
